register_file: RTL and testbench

Architectural register file with per-register rename tags. It sits beside the reorder buffer and is the other end of the ROB's launch/commit/dependency interface. It records which ROB entry will produce each register (launch) and retires values into the architectural state (commit). It also answers two combinational dependency queries per cycle for the decoder path.

---
 rtl/register_file_if.sv | 48 ++++
 rtl/register_file.sv | 77 +++++++
 tb/tb_register_file.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Launch/commit/dependency bundle between the reorder buffer and the
// architectural register file. The master side is the ROB/decoder and the
// slave side is the register file.
//
// Handshake: _rf_launch_ready and _rf_commit_ready are single-cycle strobes.
// Each one is sampled on a rising clock edge while the register file's rdy_in
// is high, and it carries the rob_id, register_id and value sampled on that
// same edge. There is no back-pressure: the register file always accepts a
// strobe while rdy_in is high. While rdy_in is low, strobes are ignored rather
// than held. The two dependency queries are purely combinational and have no
// handshake.
interface register_file_if #(
  parameter int TAGW = 5,
  parameter int RIDW = 5
);
  logic            _clear;
  logic            _rf_launch_ready;
  logic [TAGW-1:0] _rf_launch_rob_id;
  logic [RIDW-1:0] _rf_launch_register_id;
  logic            _rf_commit_ready;
  logic [TAGW-1:0] _rf_commit_rob_id;
  logic [RIDW-1:0] _rf_commit_register_id;
  logic [31:0]     _rf_commit_value;
  logic [RIDW-1:0] _ask_rd_1;
  logic [RIDW-1:0] _ask_rd_2;
  logic [TAGW-1:0] _dep_rd_1;
  logic [TAGW-1:0] _dep_rd_2;
  logic [31:0]     _dep_value_1;
  logic [31:0]     _dep_value_2;

  modport master (
    output _clear,
    output _rf_launch_ready, _rf_launch_rob_id, _rf_launch_register_id,
    output _rf_commit_ready, _rf_commit_rob_id, _rf_commit_register_id,
    output _rf_commit_value,
    output _ask_rd_1, _ask_rd_2,
    input  _dep_rd_1, _dep_rd_2, _dep_value_1, _dep_value_2
  );

  modport slave (
    input  _clear,
    input  _rf_launch_ready, _rf_launch_rob_id, _rf_launch_register_id,
    input  _rf_commit_ready, _rf_commit_rob_id, _rf_commit_register_id,
    input  _rf_commit_value,
    input  _ask_rd_1, _ask_rd_2,
    output _dep_rd_1, _dep_rd_2, _dep_value_1, _dep_value_2
  );
endinterface

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags.
// Launch records which ROB entry will produce a register. Commit retires a
// value and drops the tag only if the retiring ROB id still owns the register.
// A flush clears every tag but keeps the values. x0 has no storage and always
// reads as tag 0, value 0. Query outputs come straight from registered state:
// there is no forwarding of same-cycle launch or commit.
module register_file #(
  parameter int NREG = 32,
  parameter int TAGW = 5
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  register_file_if.slave bus
);

  logic [31:0]     value_q [1:NREG-1];
  logic [TAGW-1:0] tag_q   [1:NREG-1];

  logic commit_hit;
  logic launch_hit;

  // A write is effective only for a real, in-range register (x0 is discarded).
  always_comb begin
    commit_hit = bus._rf_commit_ready &&
                 (bus._rf_commit_register_id != '0) &&
                 (int'(bus._rf_commit_register_id) < NREG);
    launch_hit = bus._rf_launch_ready && !bus._clear &&
                 (bus._rf_launch_register_id != '0) &&
                 (int'(bus._rf_launch_register_id) < NREG);
  end

  // State update. The order of statements gives the priority on tags:
  // commit clears, then launch overrides, then clear overrides everything.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 1; i < NREG; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (commit_hit) begin
        value_q[bus._rf_commit_register_id] <= bus._rf_commit_value;
        // A younger producer may already own this register; keep its tag.
        if (tag_q[bus._rf_commit_register_id] == bus._rf_commit_rob_id)
          tag_q[bus._rf_commit_register_id] <= '0;
      end
      if (launch_hit)
        tag_q[bus._rf_launch_register_id] <= bus._rf_launch_rob_id;
      if (bus._clear) begin
        for (int i = 1; i < NREG; i++)
          tag_q[i] <= '0;
      end
    end
  end

  // Query port 1: combinational read of the registered state, x0 reads as zero.
  always_comb begin
    bus._dep_rd_1    = '0;
    bus._dep_value_1 = '0;
    if (bus._ask_rd_1 != '0 && int'(bus._ask_rd_1) < NREG) begin
      bus._dep_rd_1    = tag_q[bus._ask_rd_1];
      bus._dep_value_1 = value_q[bus._ask_rd_1];
    end
  end

  // Query port 2: same as port 1, for the second source operand.
  always_comb begin
    bus._dep_rd_2    = '0;
    bus._dep_value_2 = '0;
    if (bus._ask_rd_2 != '0 && int'(bus._ask_rd_2) < NREG) begin
      bus._dep_rd_2    = tag_q[bus._ask_rd_2];
      bus._dep_value_2 = value_q[bus._ask_rd_2];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: one task per scenario, each with its
// own hand-computed expectations.
module tb_register_file;

  logic clk_in;
  logic rst_in;
  logic rdy_in;

  int checks;
  int failures;

  register_file_if bus ();

  register_file dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  // Clock generation
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Driver: drop all strobes
  task automatic idle();
    bus._clear                 = 1'b0;
    bus._rf_launch_ready       = 1'b0;
    bus._rf_launch_rob_id      = '0;
    bus._rf_launch_register_id = '0;
    bus._rf_commit_ready       = 1'b0;
    bus._rf_commit_rob_id      = '0;
    bus._rf_commit_register_id = '0;
    bus._rf_commit_value       = '0;
  endtask

  // Driver: present a launch for the next edge
  task automatic drive_launch(input logic [4:0] rd, input logic [4:0] id);
    bus._rf_launch_ready       = 1'b1;
    bus._rf_launch_register_id = rd;
    bus._rf_launch_rob_id      = id;
  endtask

  // Driver: present a commit for the next edge
  task automatic drive_commit(input logic [4:0] rd, input logic [4:0] id,
                              input logic [31:0] val);
    bus._rf_commit_ready       = 1'b1;
    bus._rf_commit_register_id = rd;
    bus._rf_commit_rob_id      = id;
    bus._rf_commit_value       = val;
  endtask

  // Driver: take one edge, then drop strobes #1 after it
  task automatic step();
    @(posedge clk_in);
    #1;
    idle();
  endtask

  // Driver: set both query addresses and let the combinational path settle
  task automatic ask(input logic [4:0] a1, input logic [4:0] a2);
    bus._ask_rd_1 = a1;
    bus._ask_rd_2 = a2;
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    rdy_in = 1'b1;
    idle();
    ask(5'd5, 5'd31);
    repeat (2) @(posedge clk_in);
    #2 rst_in = 1'b1;
    drive_launch(5'd5, 5'd3);
    drive_commit(5'd31, 5'd1, 32'h0000_CAFE);
    step();
    ask(5'd5, 5'd31);
    checks++;
    if (bus._dep_rd_1 !== 5'd3) begin
      failures++;
      $display("FAIL reset_prelaunch_tag got=%0d exp=3", bus._dep_rd_1);
    end
    checks++;
    if (bus._dep_value_2 !== 32'h0000_CAFE) begin
      failures++;
      $display("FAIL reset_precommit_value got=%h exp=0000cafe", bus._dep_value_2);
    end
    // Mid-cycle reset pulse, no clock edge in between
    #1 rst_in = 1'b0;
    #1;
    checks++;
    if (bus._dep_rd_1 !== 5'd0) begin
      failures++;
      $display("FAIL reset_tag_x5 got=%0d exp=0", bus._dep_rd_1);
    end
    checks++;
    if (bus._dep_value_1 !== 32'd0) begin
      failures++;
      $display("FAIL reset_value_x5 got=%h exp=0", bus._dep_value_1);
    end
    checks++;
    if (bus._dep_rd_2 !== 5'd0) begin
      failures++;
      $display("FAIL reset_tag_x31 got=%0d exp=0", bus._dep_rd_2);
    end
    checks++;
    if (bus._dep_value_2 !== 32'd0) begin
      failures++;
      $display("FAIL reset_value_x31 got=%h exp=0", bus._dep_value_2);
    end
    #1 rst_in = 1'b1;
    step();
    ask(5'd5, 5'd31);
    checks++;
    if (bus._dep_rd_1 !== 5'd0 || bus._dep_value_2 !== 32'd0) begin
      failures++;
      $display("FAIL reset_after_release got_tag=%0d got_val=%h exp=0/0",
               bus._dep_rd_1, bus._dep_value_2);
    end
  endtask

  task automatic test_launch_commit();
    drive_launch(5'd3, 5'd7);
    step();
    ask(5'd3, 5'd0);
    checks++;
    if (bus._dep_rd_1 !== 5'd7) begin
      failures++;
      $display("FAIL launch_tag_x3 got=%0d exp=7", bus._dep_rd_1);
    end
    drive_commit(5'd3, 5'd7, 32'hDEAD_BEEF);
    step();
    ask(5'd3, 5'd3);
    checks++;
    if (bus._dep_rd_1 !== 5'd0) begin
      failures++;
      $display("FAIL commit_tag_x3 got=%0d exp=0", bus._dep_rd_1);
    end
    checks++;
    if (bus._dep_value_2 !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL commit_value_x3 got=%h exp=deadbeef", bus._dep_value_2);
    end
  endtask

  task automatic test_stale_commit();
    drive_launch(5'd4, 5'd2);
    step();
    drive_launch(5'd4, 5'd9);
    step();
    drive_commit(5'd4, 5'd2, 32'h0000_0011);
    step();
    ask(5'd4, 5'd4);
    checks++;
    if (bus._dep_rd_1 !== 5'd9) begin
      failures++;
      $display("FAIL stale_tag_x4 got=%0d exp=9", bus._dep_rd_1);
    end
    checks++;
    if (bus._dep_value_2 !== 32'h0000_0011) begin
      failures++;
      $display("FAIL stale_value_x4 got=%h exp=00000011", bus._dep_value_2);
    end
    // Same register: commit of owner plus launch of a younger producer
    drive_commit(5'd4, 5'd9, 32'h0000_0022);
    drive_launch(5'd4, 5'd12);
    step();
    ask(5'd4, 5'd4);
    checks++;
    if (bus._dep_rd_1 !== 5'd12) begin
      failures++;
      $display("FAIL same_cycle_tag_x4 got=%0d exp=12", bus._dep_rd_1);
    end
    checks++;
    if (bus._dep_value_2 !== 32'h0000_0022) begin
      failures++;
      $display("FAIL same_cycle_value_x4 got=%h exp=00000022", bus._dep_value_2);
    end
  endtask

  task automatic test_clear();
    for (int i = 1; i <= 3; i++) begin
      drive_launch(5'(i), 5'(i));
      step();
    end
    ask(5'd2, 5'd3);
    checks++;
    if (bus._dep_rd_1 !== 5'd2 || bus._dep_rd_2 !== 5'd3) begin
      failures++;
      $display("FAIL preclear_tags got=%0d/%0d exp=2/3", bus._dep_rd_1, bus._dep_rd_2);
    end
    bus._clear = 1'b1;
    drive_commit(5'd1, 5'd1, 32'd5);
    drive_launch(5'd6, 5'd4);
    step();
    ask(5'd1, 5'd6);
    checks++;
    if (bus._dep_rd_1 !== 5'd0 || bus._dep_rd_2 !== 5'd0) begin
      failures++;
      $display("FAIL clear_tags_x1_x6 got=%0d/%0d exp=0/0", bus._dep_rd_1, bus._dep_rd_2);
    end
    checks++;
    if (bus._dep_value_1 !== 32'd5) begin
      failures++;
      $display("FAIL clear_value_x1 got=%h exp=5", bus._dep_value_1);
    end
    ask(5'd2, 5'd3);
    checks++;
    if (bus._dep_rd_1 !== 5'd0 || bus._dep_rd_2 !== 5'd0) begin
      failures++;
      $display("FAIL clear_tags_x2_x3 got=%0d/%0d exp=0/0", bus._dep_rd_1, bus._dep_rd_2);
    end
    ask(5'd3, 5'd4);
    checks++;
    if (bus._dep_value_1 !== 32'hDEAD_BEEF || bus._dep_value_2 !== 32'h0000_0022) begin
      failures++;
      $display("FAIL clear_keeps_values got=%h/%h exp=deadbeef/00000022",
               bus._dep_value_1, bus._dep_value_2);
    end
  endtask

  task automatic test_back_to_back();
    // Commit and launch to different registers on the same edge
    drive_commit(5'd10, 5'd5, 32'h0000_A5A5);
    drive_launch(5'd11, 5'd31);
    step();
    ask(5'd10, 5'd11);
    checks++;
    if (bus._dep_value_1 !== 32'h0000_A5A5 || bus._dep_rd_1 !== 5'd0) begin
      failures++;
      $display("FAIL diff_regs_x10 got_val=%h got_tag=%0d exp=0000a5a5/0",
               bus._dep_value_1, bus._dep_rd_1);
    end
    checks++;
    if (bus._dep_rd_2 !== 5'd31) begin
      failures++;
      $display("FAIL diff_regs_tag_x11 got=%0d exp=31", bus._dep_rd_2);
    end
    // Tag wrap: id 1 launched while id 31 commits the same register
    drive_launch(5'd11, 5'd1);
    drive_commit(5'd11, 5'd31, 32'h1234_5678);
    step();
    ask(5'd11, 5'd11);
    checks++;
    if (bus._dep_rd_1 !== 5'd1 || bus._dep_value_2 !== 32'h1234_5678) begin
      failures++;
      $display("FAIL wrap_x11 got_tag=%0d got_val=%h exp=1/12345678",
               bus._dep_rd_1, bus._dep_value_2);
    end
  endtask

  task automatic test_x0();
    drive_launch(5'd0, 5'd6);
    drive_commit(5'd0, 5'd6, 32'h0000_0055);
    step();
    ask(5'd0, 5'd0);
    checks++;
    if (bus._dep_rd_1 !== 5'd0 || bus._dep_value_2 !== 32'd0) begin
      failures++;
      $display("FAIL x0_write got_tag=%0d got_val=%h exp=0/0",
               bus._dep_rd_1, bus._dep_value_2);
    end
  endtask

  task automatic test_rdy();
    rdy_in = 1'b0;
    drive_launch(5'd8, 5'd3);
    drive_commit(5'd9, 5'd0, 32'h0000_0077);
    step();
    ask(5'd8, 5'd9);
    checks++;
    if (bus._dep_rd_1 !== 5'd0) begin
      failures++;
      $display("FAIL rdy_low_tag_x8 got=%0d exp=0", bus._dep_rd_1);
    end
    checks++;
    if (bus._dep_value_2 !== 32'd0) begin
      failures++;
      $display("FAIL rdy_low_value_x9 got=%h exp=0", bus._dep_value_2);
    end
    // Queries still follow the address while rdy_in is low
    ask(5'd1, 5'd11);
    checks++;
    if (bus._dep_value_1 !== 32'd5 || bus._dep_rd_2 !== 5'd1) begin
      failures++;
      $display("FAIL rdy_low_query got_val=%h got_tag=%0d exp=5/1",
               bus._dep_value_1, bus._dep_rd_2);
    end
    rdy_in = 1'b1;
    drive_launch(5'd8, 5'd3);
    step();
    ask(5'd8, 5'd0);
    checks++;
    if (bus._dep_rd_1 !== 5'd3) begin
      failures++;
      $display("FAIL rdy_high_tag_x8 got=%0d exp=3", bus._dep_rd_1);
    end
  endtask

  // Sequence and final report
  initial begin
    checks   = 0;
    failures = 0;
    bus._ask_rd_1 = '0;
    bus._ask_rd_2 = '0;
    test_reset();
    test_launch_commit();
    test_stale_commit();
    test_clear();
    test_back_to_back();
    test_x0();
    test_rdy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
